// File: rtl/ctrl_pkt_arbiter_pkg.sv
// Shared ctrl-path header: bus widths, ctrl packet field offsets and
// the arbiter state encoding.
package ctrl_pkt_arbiter_pkg;

  localparam int CTRL_DW = 256;
  localparam int CTRL_UW = 128;

  // Field offsets inside a ctrl packet that the pipeline stages decode.
  localparam int CTRL_TUSER_LEN_LSB = 0;
  localparam int CTRL_MODID_LSB     = 112;
  localparam int CTRL_MODID_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_DROP,
    ST_GAP
  } arb_state_e;

endpackage

// File: rtl/ctrl_pkt_arbiter_rr_arb2.sv
// Two-way round-robin grant. The last winner is remembered and loses the
// next tie; it is only updated when the owner commits a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       grant_o,
  output logic       valid_o
);

  logic last_q;

  always_comb begin
    valid_o = |req_i;
    grant_o = req_i[1];
    if (&req_i) begin
      grant_o = ~last_q;
    end
  end

  // Reset value of 1 lets source 0 win the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (update_i && valid_o) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/ctrl_pkt_arbiter.sv
// Packet-atomic merge of two ctrl-packet sources onto the ctrl chain,
// with truncation of over-long packets and an enforced idle gap.
module ctrl_pkt_arbiter
  import ctrl_pkt_arbiter_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = CTRL_DW,
  parameter int C_S_AXIS_TUSER_WIDTH = CTRL_UW,
  parameter int MIN_GAP              = 4,
  parameter int MAX_BEATS            = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                              s0_axis_tvalid,
  input  logic                              s0_axis_tlast,
  output logic                              s0_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                              s1_axis_tvalid,
  input  logic                              s1_axis_tlast,
  output logic                              s1_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_m_axis_tuser,
  output logic                              ctrl_m_axis_tvalid,
  output logic                              ctrl_m_axis_tlast,
  output logic                              busy
);

  localparam int KW  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int BCW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BEATS - 1);
  localparam logic [7:0]     LAST_GAP  = 8'(MIN_GAP - 1);

  arb_state_e                      state_q;
  logic                            grant_q;
  logic [BCW-1:0]                  beat_cnt_q;
  logic [7:0]                      gap_cnt_q;
  logic                            tready0_q;
  logic                            tready1_q;
  logic                            busy_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  m_tdata_q;
  logic [KW-1:0]                   m_tkeep_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] m_tuser_q;
  logic                            m_tvalid_q;
  logic                            m_tlast_q;

  logic                            arb_grant;
  logic                            arb_valid;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  sel_tdata;
  logic [KW-1:0]                   sel_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] sel_tuser;
  logic                            sel_tlast;
  logic                            accept;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({s1_axis_tvalid, s0_axis_tvalid}),
    .update_i (state_q == ST_IDLE),
    .grant_o  (arb_grant),
    .valid_o  (arb_valid)
  );

  // Granted-source mux; tready is only ever high in FWD/DROP, so accept implies those states.
  always_comb begin
    sel_tdata = s0_axis_tdata;
    sel_tkeep = s0_axis_tkeep;
    sel_tuser = s0_axis_tuser;
    sel_tlast = s0_axis_tlast;
    accept    = s0_axis_tvalid & tready0_q;
    if (grant_q) begin
      sel_tdata = s1_axis_tdata;
      sel_tkeep = s1_axis_tkeep;
      sel_tuser = s1_axis_tuser;
      sel_tlast = s1_axis_tlast;
      accept    = s1_axis_tvalid & tready1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      tready0_q  <= 1'b0;
      tready1_q  <= 1'b0;
      busy_q     <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tuser_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      m_tvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q    <= arb_grant;
            tready0_q  <= ~arb_grant;
            tready1_q  <= arb_grant;
            busy_q     <= 1'b1;
            beat_cnt_q <= '0;
            state_q    <= ST_FWD;
          end
        end
        ST_FWD, ST_DROP: begin
          if (accept) begin
            if (state_q == ST_FWD) begin
              m_tdata_q  <= sel_tdata;
              m_tkeep_q  <= sel_tkeep;
              m_tuser_q  <= sel_tuser;
              m_tvalid_q <= 1'b1;
              m_tlast_q  <= sel_tlast | (beat_cnt_q == LAST_BEAT);
            end
            if (sel_tlast) begin
              beat_cnt_q <= '0;
              tready0_q  <= 1'b0;
              tready1_q  <= 1'b0;
              if (MIN_GAP == 0) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                gap_cnt_q <= '0;
                state_q   <= ST_GAP;
              end
            end else if (state_q == ST_FWD) begin
              // Truncated packets keep tready high in DROP to swallow the tail.
              if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_q <= '0;
                state_q    <= ST_DROP;
              end else begin
                beat_cnt_q <= beat_cnt_q + BCW'(1);
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == LAST_GAP) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s0_axis_tready     = tready0_q;
  assign s1_axis_tready     = tready1_q;
  assign ctrl_m_axis_tdata  = m_tdata_q;
  assign ctrl_m_axis_tkeep  = m_tkeep_q;
  assign ctrl_m_axis_tuser  = m_tuser_q;
  assign ctrl_m_axis_tvalid = m_tvalid_q;
  assign ctrl_m_axis_tlast  = m_tlast_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_ctrl_pkt_arbiter.sv
// Scoreboard bench for ctrl_pkt_arbiter: directed packets push expected beats,
// a negedge monitor pops and compares every output beat.
module tb_ctrl_pkt_arbiter;

  localparam int DW        = 256;
  localparam int UW        = 128;
  localparam int KW        = DW / 8;
  localparam int MIN_GAP   = 4;
  localparam int MAX_BEATS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep, s1_axis_tkeep;
  logic [UW-1:0] s0_axis_tuser, s1_axis_tuser;
  logic          s0_axis_tvalid, s1_axis_tvalid;
  logic          s0_axis_tlast, s1_axis_tlast;
  logic          s0_axis_tready, s1_axis_tready;
  logic [DW-1:0] ctrl_m_axis_tdata;
  logic [KW-1:0] ctrl_m_axis_tkeep;
  logic [UW-1:0] ctrl_m_axis_tuser;
  logic          ctrl_m_axis_tvalid;
  logic          ctrl_m_axis_tlast;
  logic          busy;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t expQ[$];
  int    checks   = 0;
  int    failures = 0;
  int    pktCnt[2];
  int    idleCnt  = 1000;
  logic  afterLast = 1'b0;

  always #5 clk = ~clk;

  ctrl_pkt_arbiter #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .MIN_GAP              (MIN_GAP),
    .MAX_BEATS            (MAX_BEATS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .s0_axis_tdata      (s0_axis_tdata),
    .s0_axis_tkeep      (s0_axis_tkeep),
    .s0_axis_tuser      (s0_axis_tuser),
    .s0_axis_tvalid     (s0_axis_tvalid),
    .s0_axis_tlast      (s0_axis_tlast),
    .s0_axis_tready     (s0_axis_tready),
    .s1_axis_tdata      (s1_axis_tdata),
    .s1_axis_tkeep      (s1_axis_tkeep),
    .s1_axis_tuser      (s1_axis_tuser),
    .s1_axis_tvalid     (s1_axis_tvalid),
    .s1_axis_tlast      (s1_axis_tlast),
    .s1_axis_tready     (s1_axis_tready),
    .ctrl_m_axis_tdata  (ctrl_m_axis_tdata),
    .ctrl_m_axis_tkeep  (ctrl_m_axis_tkeep),
    .ctrl_m_axis_tuser  (ctrl_m_axis_tuser),
    .ctrl_m_axis_tvalid (ctrl_m_axis_tvalid),
    .ctrl_m_axis_tlast  (ctrl_m_axis_tlast),
    .busy               (busy)
  );

  // Each beat carries {src, pkt, beat} so the monitor can identify its origin.
  function automatic beat_t mkBeat(int src, int pkt, int beat, logic last);
    beat_t b;
    logic [31:0] w;
    w      = {8'(src), 8'(pkt), 16'(beat)};
    b.data = {8{w}};
    b.keep = w ^ 32'h5A5A_0F0F;
    b.user = {4{~w}};
    b.last = last;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected output of one packet: truncated to MAX_BEATS with tlast forced on the last kept beat.
  task automatic pushPacket(input int src, input int pkt, input int nbeats);
    for (int b = 0; b < nbeats && b < MAX_BEATS; b++) begin
      expQ.push_back(mkBeat(src, pkt, b, (b == nbeats - 1) || (b == MAX_BEATS - 1)));
    end
  endtask

  task automatic driveSrc(input int src, input beat_t b, input logic valid);
    if (src == 0) begin
      s0_axis_tdata = b.data; s0_axis_tkeep = b.keep; s0_axis_tuser = b.user;
      s0_axis_tlast = b.last; s0_axis_tvalid = valid;
    end else begin
      s1_axis_tdata = b.data; s1_axis_tkeep = b.keep; s1_axis_tuser = b.user;
      s1_axis_tlast = b.last; s1_axis_tvalid = valid;
    end
  endtask

  function automatic logic readyOf(input int src);
    return (src == 0) ? s0_axis_tready : s1_axis_tready;
  endfunction

  // Sends one packet; an optional input bubble of bubbleLen cycles precedes beat bubbleAt.
  task automatic applyStimulus(input int src, input int pkt, input int nbeats,
                               input int bubbleAt, input int bubbleLen);
    beat_t bt;
    int waited;
    for (int b = 0; b < nbeats; b++) begin
      if (b == bubbleAt && bubbleLen > 0) begin
        driveSrc(src, mkBeat(src, pkt, b, 1'b0), 1'b0);
        repeat (bubbleLen) @(posedge clk);
        #1;
      end
      bt = mkBeat(src, pkt, b, b == nbeats - 1);
      driveSrc(src, bt, 1'b1);
      waited = 0;
      forever begin
        @(negedge clk);
        if (readyOf(src)) break;
        waited++;
        if (waited > 300) break;
      end
      if (waited > 300) begin
        checkOutput($sformatf("tready_timeout_src%0d", src), 256'(0), 256'(1));
        driveSrc(src, bt, 1'b0);
        return;
      end
      @(posedge clk);
      #1;
    end
    driveSrc(src, mkBeat(src, 0, 0, 1'b0), 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (MIN_GAP + 6) @(posedge clk);
    #1;
    checkOutput(name, 256'(expQ.size()), 256'(0));
  endtask

  // Monitor: pops the scoreboard on each output beat and checks the idle gap after tlast.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      checkOutput("tready_exclusive", 256'(s0_axis_tready & s1_axis_tready), 256'(0));
      if (ctrl_m_axis_tvalid === 1'b1) begin
        if (afterLast) begin
          checkOutput("min_gap", 256'(idleCnt >= MIN_GAP), 256'(1));
        end
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat actual=%0h required=none at %0t",
                   ctrl_m_axis_tdata[31:0], $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat_tdata", ctrl_m_axis_tdata, e.data);
          checkOutput("beat_tkeep", 256'(ctrl_m_axis_tkeep), 256'(e.keep));
          checkOutput("beat_tuser", 256'(ctrl_m_axis_tuser), 256'(e.user));
          checkOutput("beat_tlast", 256'(ctrl_m_axis_tlast), 256'(e.last));
        end
        if (ctrl_m_axis_tlast) pktCnt[ctrl_m_axis_tdata[24]]++;
        afterLast = ctrl_m_axis_tlast;
        idleCnt   = 0;
      end else begin
        idleCnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    beat_t idle;
    idle = mkBeat(0, 0, 0, 1'b0);
    reset = 1'b1;
    driveSrc(0, idle, 1'b0);
    driveSrc(1, idle, 1'b0);
    pktCnt[0] = 0;
    pktCnt[1] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", 256'(ctrl_m_axis_tvalid), 256'(0));
    checkOutput("rst_tlast", 256'(ctrl_m_axis_tlast), 256'(0));
    checkOutput("rst_tdata", ctrl_m_axis_tdata, 256'(0));
    checkOutput("rst_s0_tready", 256'(s0_axis_tready), 256'(0));
    checkOutput("rst_s1_tready", 256'(s1_axis_tready), 256'(0));
    checkOutput("rst_busy", 256'(busy), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: single 3-beat packet from s0, then MIN_GAP cycles of GAP
    pushPacket(0, 1, 3);
    applyStimulus(0, 1, 3, -1, 0);
    for (int i = 0; i < MIN_GAP; i++) begin
      @(negedge clk);
      checkOutput("t1_gap_s0_tready", 256'(s0_axis_tready), 256'(0));
      checkOutput("t1_gap_busy", 256'(busy), 256'(1));
    end
    @(negedge clk);
    checkOutput("t1_idle_busy", 256'(busy), 256'(0));
    drain("t1_queue_empty");

    // 2: simultaneous requests after reset, s0 first
    doReset();
    pushPacket(0, 2, 3);
    pushPacket(1, 3, 2);
    fork
      applyStimulus(0, 2, 3, -1, 0);
      applyStimulus(1, 3, 2, -1, 0);
    join
    drain("t2_queue_empty");

    // 3: both saturated with 2-beat packets, strict alternation
    pktCnt[0] = 0;
    pktCnt[1] = 0;
    for (int k = 0; k < 5; k++) begin
      pushPacket(0, 10 + k, 2);
      pushPacket(1, 20 + k, 2);
    end
    fork
      begin
        for (int k = 0; k < 5; k++) applyStimulus(0, 10 + k, 2, -1, 0);
      end
      begin
        for (int k = 0; k < 5; k++) applyStimulus(1, 20 + k, 2, -1, 0);
      end
    join
    drain("t3_queue_empty");
    checkOutput("t3_s0_packets", 256'(pktCnt[0]), 256'(5));
    checkOutput("t3_s1_packets", 256'(pktCnt[1]), 256'(5));

    // 4: 20-beat packet truncated at MAX_BEATS, tail absorbed
    pktCnt[1] = 0;
    pushPacket(1, 30, 20);
    applyStimulus(1, 30, 20, -1, 0);
    @(negedge clk);
    checkOutput("t4_gap_busy", 256'(busy), 256'(1));
    checkOutput("t4_gap_s1_tready", 256'(s1_axis_tready), 256'(0));
    drain("t4_queue_empty");
    checkOutput("t4_tlast_count", 256'(pktCnt[1]), 256'(1));

    // 5: s0 input bubble mid-packet while s1 waits
    pushPacket(0, 40, 4);
    pushPacket(1, 41, 2);
    fork
      applyStimulus(0, 40, 4, 2, 3);
      begin
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(1, 41, 2, -1, 0);
      end
    join
    drain("t5_queue_empty");

    // 6: reset while beat 2 of 4 is offered, then a fresh s1 packet
    expQ.push_back(mkBeat(0, 50, 0, 1'b0));
    driveSrc(0, mkBeat(0, 50, 0, 1'b0), 1'b1);
    for (int w = 0; w < 20 && !s0_axis_tready; w++) @(negedge clk);
    checkOutput("t6_beat1_tready", 256'(s0_axis_tready), 256'(1));
    @(posedge clk);
    #1;
    driveSrc(0, mkBeat(0, 50, 1, 1'b0), 1'b1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_rst_tvalid", 256'(ctrl_m_axis_tvalid), 256'(0));
    checkOutput("t6_rst_tlast", 256'(ctrl_m_axis_tlast), 256'(0));
    checkOutput("t6_rst_tdata", ctrl_m_axis_tdata, 256'(0));
    checkOutput("t6_rst_s0_tready", 256'(s0_axis_tready), 256'(0));
    checkOutput("t6_rst_busy", 256'(busy), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    driveSrc(0, idle, 1'b0);
    pushPacket(1, 51, 3);
    applyStimulus(1, 51, 3, -1, 0);
    drain("t6_queue_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
